// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg: shared types and helpers for the byte-wide memory sequencer.
//   - request size encodings
//   - sequencer state enum
//   - data-register function-select codes
//   - last_idx(): index of the final byte for a size
//   - store_byte(): MSB-first byte selection for stores
package mem_seq_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;  // 2'b11 behaves as word too

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_XFER = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam logic [1:0] DR_LOAD_SEXT = 2'b00;
    localparam logic [1:0] DR_LOAD_ZEXT = 2'b01;
    localparam logic [1:0] DR_SHL       = 2'b10;
    localparam logic [1:0] DR_SHR       = 2'b11;

    // Index of the final byte (N-1) for a size code.
    function automatic logic [1:0] last_idx(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 2'd0;
            SZ_HALF: return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    // Store byte for position idx; the lowest address gets the most
    // significant byte of the sized value.
    function automatic logic [7:0] store_byte(input logic [1:0]  size,
                                              input logic [1:0]  idx,
                                              input logic [31:0] data);
        case (size)
            SZ_BYTE: return data[7:0];
            SZ_HALF: return idx[0] ? data[7:0] : data[15:8];
            default: begin
                case (idx)
                    2'd0:    return data[31:24];
                    2'd1:    return data[23:16];
                    2'd2:    return data[15:8];
                    default: return data[7:0];
                endcase
            end
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_sequencer.sv
// mem_byte_sequencer: turns one byte/half/word load or store request into a
// sequence of byte accesses on the memory port, steering the 32-bit data
// register (sign/zero-extend first byte, then shift-left-insert) on loads.
// Loads and stores are big-endian: lowest address carries the MSB.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start_i           request strobe (accepted in IDLE only)
//   write_i           0 load / 1 store
//   size_i            00 byte, 01 half, 1x word
//   signed_i          load sign-extend select
//   addr_i            base byte address
//   store_data_i      store source value
//   busy_o, done_o    status; done_o is a one-cycle completion pulse
//   mem_addr_o        current byte address
//   mem_read_o        load byte request
//   mem_write_o       store byte request
//   mem_wr_data_o     store byte
//   mem_rd_data_i     load byte from memory
//   mem_ready_i       memory completes the current byte this cycle
//   dr_en_o           data-register enable
//   dr_fun_sel_o      data-register function select
//   dr_data_o         data-register byte input
module mem_byte_sequencer
    import mem_seq_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              write_i,
    input  logic [1:0]        size_i,
    input  logic              signed_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       store_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [7:0]        mem_wr_data_o,
    input  logic [7:0]        mem_rd_data_i,
    input  logic              mem_ready_i,
    output logic              dr_en_o,
    output logic [1:0]        dr_fun_sel_o,
    output logic [7:0]        dr_data_o
);

    state_e            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [31:0]       data_q, data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= 2'd0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= SZ_BYTE;
            signed_q <= 1'b0;
            data_q   <= 32'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            data_q   <= data_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        addr_d        = addr_q;
        write_d       = write_q;
        size_d        = size_q;
        signed_d      = signed_q;
        data_d        = data_q;
        busy_o        = (state_q != ST_IDLE);
        done_o        = 1'b0;
        mem_read_o    = 1'b0;
        mem_write_o   = 1'b0;
        mem_wr_data_o = 8'd0;
        dr_en_o       = 1'b0;
        dr_fun_sel_o  = DR_LOAD_SEXT;
        dr_data_o     = 8'd0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d  = ST_XFER;
                    idx_d    = 2'd0;
                    addr_d   = addr_i;
                    write_d  = write_i;
                    size_d   = size_i;
                    signed_d = signed_i;
                    data_d   = store_data_i;
                end
            end
            ST_XFER: begin
                if (write_q) begin
                    mem_write_o   = 1'b1;
                    mem_wr_data_o = store_byte(size_q, idx_q, data_q);
                end else begin
                    // Data register captures on the same edge memory completes.
                    mem_read_o   = 1'b1;
                    dr_data_o    = mem_rd_data_i;
                    dr_en_o      = mem_ready_i;
                    dr_fun_sel_o = (idx_q != 2'd0) ? DR_SHL :
                                   (signed_q ? DR_LOAD_SEXT : DR_LOAD_ZEXT);
                end
                if (mem_ready_i) begin
                    if (idx_q == last_idx(size_q)) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d  = idx_q + 2'd1;
                        addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_addr_o = addr_q;

endmodule

// File: tb/tb_mem_byte_sequencer.sv
module tb_mem_byte_sequencer;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, write, sgn, ready;
    logic [1:0]    size;
    logic [AW-1:0] addr;
    logic [31:0]   sdata;
    logic          busy, done, mem_read, mem_write, dr_en;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wr_data, mem_rd_data, dr_data;
    logic [1:0]    dr_fun_sel;

    always #5 clk = ~clk;

    mem_byte_sequencer #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .write_i(write),
        .size_i(size), .signed_i(sgn), .addr_i(addr), .store_data_i(sdata),
        .busy_o(busy), .done_o(done), .mem_addr_o(mem_addr),
        .mem_read_o(mem_read), .mem_write_o(mem_write),
        .mem_wr_data_o(mem_wr_data), .mem_rd_data_i(mem_rd_data),
        .mem_ready_i(ready), .dr_en_o(dr_en), .dr_fun_sel_o(dr_fun_sel),
        .dr_data_o(dr_data)
    );

    // Byte-addressed memory and the 32-bit data register it feeds.
    logic [7:0]  mem [0:65535];
    logic [31:0] dr;
    assign mem_rd_data = mem[mem_addr];

    int checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {logic [15:0] a; bit wr; logic [7:0] wd; logic [1:0] fs;} beat_t;
    typedef struct {bit ld; logic [31:0] val; int lat;} cmp_t;
    beat_t bq[$];
    cmp_t  cq[$];
    bit    sb_off = 1'b0;
    bit    cnt_on = 1'b0;
    int    cnt = 0;

    // Monitor: samples on the falling edge, i.e. just before the edge that
    // commits whatever is on the bus.
    always @(negedge clk) begin
        beat_t b;
        cmp_t  c;
        if (!rst_n || sb_off) begin
            cnt_on = 1'b0;
        end else begin
            if (cnt_on) cnt++;
            if (!(busy && !done)) begin
                chk("idle_strobes", {mem_read, mem_write, dr_en}, 3'b000);
            end else if (bq.size() == 0) begin
                chk("unexpected_xfer", 1, 0);
            end else begin
                b = bq[0];
                chk("mem_addr", mem_addr, b.a);
                chk("strobes", {mem_read, mem_write}, {!b.wr, b.wr});
                if (b.wr) begin
                    chk("wr_data", mem_wr_data, b.wd);
                    chk("dr_en_store", dr_en, 0);
                end else begin
                    chk("fun_sel", dr_fun_sel, b.fs);
                    chk("dr_en", dr_en, ready);
                    chk("dr_data", dr_data, mem_rd_data);
                end
                if (ready) begin
                    void'(bq.pop_front());
                    if (mem_write) mem[mem_addr] = mem_wr_data;
                    if (dr_en) begin
                        case (dr_fun_sel)
                            2'b00:   dr = {{24{dr_data[7]}}, dr_data};
                            2'b01:   dr = {24'd0, dr_data};
                            2'b10:   dr = {dr[23:0], dr_data};
                            default: dr = {dr_data, dr[31:8]};
                        endcase
                    end
                end
            end
            if (done) begin
                if (cq.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    c = cq.pop_front();
                    chk("latency", cnt, c.lat);
                    if (c.ld) chk("dr_value", dr, c.val);
                end
                cnt_on = 1'b0;
            end
            if (start && !busy) begin
                cnt_on = 1'b1;
                cnt    = 0;
            end
        end
    end

    // Issue one request; st[i] = stall cycles before byte i completes.
    task automatic run_req(input bit wr, input logic [1:0] sz, input bit sg,
                           input logic [15:0] a, input logic [31:0] d,
                           input int st[4], input bit rnd_start);
        int    n;
        bit    rq[$];
        logic [31:0] raw;
        logic [15:0] ai;
        beat_t b;
        cmp_t  c;
        int    k;
        bit    seen;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        raw = 32'd0;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < st[i]; j++) rq.push_back(1'b0);
            rq.push_back(1'b1);
            ai   = a + 16'(i);
            b.a  = ai;
            b.wr = wr;
            b.wd = 8'(d >> (8 * (n - 1 - i)));
            b.fs = (i == 0) ? (sg ? 2'b00 : 2'b01) : 2'b10;
            bq.push_back(b);
            raw = {raw[23:0], mem[ai]};
        end
        if (n == 1)      raw = sg ? {{24{raw[7]}}, raw[7:0]}   : raw;
        else if (n == 2) raw = sg ? {{16{raw[15]}}, raw[15:0]} : raw;
        c.ld  = !wr;
        c.val = raw;
        c.lat = rq.size() + 1;
        cq.push_back(c);

        @(posedge clk); #1;
        start = 1'b1; write = wr; size = sz; sgn = sg; addr = a; sdata = d;
        ready = 1'($urandom);
        @(posedge clk); #1;
        seen = 1'b0;
        for (k = 0; k < 100; k++) begin
            ready = (k < rq.size()) ? rq[k] : 1'($urandom);
            start = rnd_start ? 1'($urandom) : 1'b0;
            write = 1'($urandom); size = 2'($urandom); sgn = 1'($urandom);
            addr = 16'($urandom); sdata = $urandom;
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!seen) begin
            chk("done_timeout", 0, 1);
            bq.delete();
            cq.delete();
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        int z[4], s[4];
        logic [15:0] ra;
        z = '{0, 0, 0, 0};
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        dr = 32'd0;
        rst_n = 1'b0; start = 0; write = 0; size = 0; sgn = 0; ready = 0;
        addr = 0; sdata = 0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_strobes", {mem_read, mem_write, dr_en}, 0);
        chk("rst_wdata", mem_wr_data, 0);
        chk("rst_fs_drdata", {dr_fun_sel, dr_data}, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Word load, unsigned
        mem[16'h0100] = 8'h12; mem[16'h0101] = 8'h34;
        mem[16'h0102] = 8'h56; mem[16'h0103] = 8'h78;
        run_req(0, 2'b10, 0, 16'h0100, 0, z, 0);
        chk("dr_word", dr, 32'h12345678);

        // Signed and unsigned half loads
        mem[16'h0200] = 8'hF3; mem[16'h0201] = 8'h21;
        run_req(0, 2'b01, 1, 16'h0200, 0, z, 0);
        chk("dr_half_s", dr, 32'hFFFFF321);
        run_req(0, 2'b01, 0, 16'h0200, 0, z, 0);
        chk("dr_half_u", dr, 32'h0000F321);

        // Word store wrapping the top of memory, 2 stalls on byte 1
        s = '{0, 2, 0, 0};
        run_req(1, 2'b10, 0, 16'hFFFE, 32'hDEADBEEF, s, 1);
        chk("st_fffe", mem[16'hFFFE], 8'hDE);
        chk("st_ffff", mem[16'hFFFF], 8'hAD);
        chk("st_0000", mem[16'h0000], 8'hBE);
        chk("st_0001", mem[16'h0001], 8'hEF);

        // Byte store with Start noise during XFER/DONE
        run_req(1, 2'b00, 0, 16'h0400, 32'h000000A5, z, 1);
        chk("st_byte", mem[16'h0400], 8'hA5);

        // Reset during byte 2 of a word load
        @(posedge clk); #1;
        sb_off = 1'b1;
        start = 1; write = 0; size = 2'b10; sgn = 0; addr = 16'h0300; ready = 1;
        @(posedge clk); #1 start = 0;
        @(posedge clk); #1 ready = 0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy_done", {busy, done}, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_strobes", {mem_read, mem_write, dr_en}, 0);
        chk("mid_rst_data", {mem_wr_data, dr_fun_sel, dr_data}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; ready = 1;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_idle", {busy, done}, 0);
        end
        bq.delete();
        cq.delete();
        sb_off = 1'b0;

        // Randomized requests
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 4; i++) s[i] = $urandom_range(0, 2);
            ra = 16'($urandom);
            run_req(1'($urandom), 2'($urandom), 1'($urandom), ra, $urandom, s, 1'($urandom));
        end

        repeat (3) @(posedge clk);
        if (bq.size() != 0 || cq.size() != 0) chk("sb_drained", bq.size() + cq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
